// File: rtl/npu_ve_lane_arbiter.sv
// Lane arbiter for the stream vector engine: shares the 16-lane datapath between NN post-processing and RVV.
// Optional macro NPU_VE_ARB_STRAY_CHK_EN adds the sticky stray-beat error output err_o.
module npu_ve_lane_arbiter #(
  parameter int CMD_ID_W = 8,
  parameter int LEN_W    = 8,
  parameter int LANE_LAT = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                nn_cmd_vld_i,
  output logic                nn_cmd_rdy_o,
  input  logic [CMD_ID_W-1:0] nn_cmd_id_i,
  input  logic [LEN_W-1:0]    nn_cmd_len_i,
  input  logic                nn_post_vld_i,
  input  logic                rvv_req_vld_i,
  output logic                rvv_req_rdy_o,
  input  logic [LEN_W-1:0]    rvv_req_len_i,
  output logic                rvv_gnt_o,
  input  logic                rvv_beat_vld_i,
  output logic                lane_sel_nn_o,
  output logic                lane_in_vld_o,
  output logic                nn_cmd_done_o,
  output logic [CMD_ID_W-1:0] nn_cmd_id_done_o,
  output logic                rvv_done_o
`ifdef NPU_VE_ARB_STRAY_CHK_EN
  , output logic              err_o
`endif
);

  typedef enum logic [2:0] {IDLE, NN, RVV, DRAIN, DONE} state_t;

  localparam bit         LAT_ZERO   = (LANE_LAT == 0);
  localparam logic [3:0] DRAIN_INIT = LAT_ZERO ? 4'd0 : 4'(LANE_LAT - 1);

  state_t                state;
  logic [LEN_W-1:0]      rem;
  logic [CMD_ID_W-1:0]   id_q;
  logic                  owner_nn;
  logic                  last_nn;
  logic                  sel_q;
  logic [3:0]            drain_cnt;
  logic                  nn_win;
  logic                  beat;
  logic                  last_beat;
  logic                  to_done;
  logic                  stray;

  always_comb begin
    // NN wins a tie unless it was the last one served.
    nn_win        = nn_cmd_vld_i & (~rvv_req_vld_i | ~last_nn);
    nn_cmd_rdy_o  = (state == IDLE) & nn_win;
    rvv_req_rdy_o = (state == IDLE) & rvv_req_vld_i & ~nn_win;
    beat          = ((state == NN) & nn_post_vld_i) | ((state == RVV) & rvv_beat_vld_i);
    last_beat     = beat & (rem == '0);
    to_done       = (last_beat & LAT_ZERO) | ((state == DRAIN) & (drain_cnt == '0));
    stray         = (nn_post_vld_i & (state != NN)) | (rvv_beat_vld_i & (state != RVV));
    lane_in_vld_o = beat;
    rvv_gnt_o     = (state == RVV);
    case (state)
      NN:      lane_sel_nn_o = 1'b1;
      RVV:     lane_sel_nn_o = 1'b0;
      default: lane_sel_nn_o = sel_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      rem              <= '0;
      id_q             <= '0;
      owner_nn         <= 1'b0;
      last_nn          <= 1'b0;
      sel_q            <= 1'b0;
      drain_cnt        <= '0;
      nn_cmd_done_o    <= 1'b0;
      nn_cmd_id_done_o <= '0;
      rvv_done_o       <= 1'b0;
    end else begin
      nn_cmd_done_o <= to_done & owner_nn;
      rvv_done_o    <= to_done & ~owner_nn;
      if (to_done && owner_nn) nn_cmd_id_done_o <= id_q;
      case (state)
        IDLE: begin
          if (nn_cmd_rdy_o) begin
            id_q     <= nn_cmd_id_i;
            rem      <= nn_cmd_len_i;
            owner_nn <= 1'b1;
            last_nn  <= 1'b1;
            state    <= NN;
          end else if (rvv_req_rdy_o) begin
            rem      <= rvv_req_len_i;
            owner_nn <= 1'b0;
            last_nn  <= 1'b0;
            state    <= RVV;
          end
        end
        NN, RVV: begin
          sel_q <= (state == NN);
          if (last_beat) begin
            drain_cnt <= DRAIN_INIT;
            state     <= LAT_ZERO ? DONE : DRAIN;
          end else if (beat) begin
            rem <= rem - 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= DONE;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NPU_VE_ARB_STRAY_CHK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   err_o <= 1'b0;
    else if (stray) err_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_npu_ve_lane_arbiter.sv
// Table-driven bench for npu_ve_lane_arbiter: one LANE_LAT=4 and one LANE_LAT=0 instance on shared stimulus.
module tb_npu_ve_lane_arbiter;

  typedef struct {
    logic       rstn, nv;
    logic [7:0] id, nlen;
    logic       pv, rv;
    logic [7:0] rlen;
    logic       rb;
    logic       nrdy, rrdy, gnt, sel, lv, nd;
    logic [7:0] eid;
    logic       rd, err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, nn_cmd_vld, nn_post_vld, rvv_req_vld, rvv_beat_vld;
  logic [7:0] nn_cmd_id, nn_cmd_len, rvv_req_len;

  logic       o4_nrdy, o4_rrdy, o4_gnt, o4_sel, o4_lv, o4_nd, o4_rd;
  logic [7:0] o4_id;
  logic       o0_nrdy, o0_rrdy, o0_gnt, o0_sel, o0_lv, o0_nd, o0_rd;
  logic [7:0] o0_id;
`ifdef NPU_VE_ARB_STRAY_CHK_EN
  logic       o4_err, o0_err, a_err;
`endif

  logic       use0;
  logic       a_nrdy, a_rrdy, a_gnt, a_sel, a_lv, a_nd, a_rd;
  logic [7:0] a_id;

  vec_t tbl[$];
  vec_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   step   = 0;
  int   lv_seen;

  npu_ve_lane_arbiter #(.CMD_ID_W(8), .LEN_W(8), .LANE_LAT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .nn_cmd_vld_i(nn_cmd_vld), .nn_cmd_rdy_o(o4_nrdy), .nn_cmd_id_i(nn_cmd_id),
    .nn_cmd_len_i(nn_cmd_len), .nn_post_vld_i(nn_post_vld),
    .rvv_req_vld_i(rvv_req_vld), .rvv_req_rdy_o(o4_rrdy), .rvv_req_len_i(rvv_req_len),
    .rvv_gnt_o(o4_gnt), .rvv_beat_vld_i(rvv_beat_vld),
    .lane_sel_nn_o(o4_sel), .lane_in_vld_o(o4_lv),
    .nn_cmd_done_o(o4_nd), .nn_cmd_id_done_o(o4_id), .rvv_done_o(o4_rd)
`ifdef NPU_VE_ARB_STRAY_CHK_EN
    , .err_o(o4_err)
`endif
  );

  npu_ve_lane_arbiter #(.CMD_ID_W(8), .LEN_W(8), .LANE_LAT(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .nn_cmd_vld_i(nn_cmd_vld), .nn_cmd_rdy_o(o0_nrdy), .nn_cmd_id_i(nn_cmd_id),
    .nn_cmd_len_i(nn_cmd_len), .nn_post_vld_i(nn_post_vld),
    .rvv_req_vld_i(rvv_req_vld), .rvv_req_rdy_o(o0_rrdy), .rvv_req_len_i(rvv_req_len),
    .rvv_gnt_o(o0_gnt), .rvv_beat_vld_i(rvv_beat_vld),
    .lane_sel_nn_o(o0_sel), .lane_in_vld_o(o0_lv),
    .nn_cmd_done_o(o0_nd), .nn_cmd_id_done_o(o0_id), .rvv_done_o(o0_rd)
`ifdef NPU_VE_ARB_STRAY_CHK_EN
    , .err_o(o0_err)
`endif
  );

  always_comb begin
    a_nrdy = use0 ? o0_nrdy : o4_nrdy;
    a_rrdy = use0 ? o0_rrdy : o4_rrdy;
    a_gnt  = use0 ? o0_gnt  : o4_gnt;
    a_sel  = use0 ? o0_sel  : o4_sel;
    a_lv   = use0 ? o0_lv   : o4_lv;
    a_nd   = use0 ? o0_nd   : o4_nd;
    a_id   = use0 ? o0_id   : o4_id;
    a_rd   = use0 ? o0_rd   : o4_rd;
`ifdef NPU_VE_ARB_STRAY_CHK_EN
    a_err  = use0 ? o0_err  : o4_err;
`endif
  end

  function automatic vec_t mk(int rstn, int nv, int id, int nlen, int pv, int rv, int rlen, int rb,
                              int nrdy, int rrdy, int gnt, int sel, int lv, int nd, int eid,
                              int rd, int err);
    vec_t v;
    v.rstn = 1'(rstn); v.nv = 1'(nv); v.id = 8'(id); v.nlen = 8'(nlen);
    v.pv = 1'(pv); v.rv = 1'(rv); v.rlen = 8'(rlen); v.rb = 1'(rb);
    v.nrdy = 1'(nrdy); v.rrdy = 1'(rrdy); v.gnt = 1'(gnt); v.sel = 1'(sel);
    v.lv = 1'(lv); v.nd = 1'(nd); v.eid = 8'(eid); v.rd = 1'(rd); v.err = 1'(err);
    return v;
  endfunction

  task automatic add(input vec_t v, input int n);
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", nm, step, act, exp);
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(posedge clk); #1;
    reset_n      = v.rstn;
    nn_cmd_vld   = v.nv;
    nn_cmd_id    = v.id;
    nn_cmd_len   = v.nlen;
    nn_post_vld  = v.pv;
    rvv_req_vld  = v.rv;
    rvv_req_len  = v.rlen;
    rvv_beat_vld = v.rb;
    sbq.push_back(v);
    @(negedge clk);
    e = sbq.pop_front();
    chk("nn_cmd_rdy", 32'(a_nrdy), 32'(e.nrdy));
    chk("rvv_req_rdy", 32'(a_rrdy), 32'(e.rrdy));
    chk("rvv_gnt", 32'(a_gnt), 32'(e.gnt));
    chk("lane_sel_nn", 32'(a_sel), 32'(e.sel));
    chk("lane_in_vld", 32'(a_lv), 32'(e.lv));
    chk("nn_cmd_done", 32'(a_nd), 32'(e.nd));
    if (e.nd || !e.rstn) chk("nn_cmd_id_done", 32'(a_id), 32'(e.eid));
    chk("rvv_done", 32'(a_rd), 32'(e.rd));
`ifdef NPU_VE_ARB_STRAY_CHK_EN
    chk("err", 32'(a_err), 32'(e.err));
`endif
    if (a_lv === 1'b1) lv_seen++;
    step++;
  endtask

  initial begin
    int k, nb, pv;
    reset_n = 1'b0; nn_cmd_vld = 1'b0; nn_cmd_id = '0; nn_cmd_len = '0; nn_post_vld = 1'b0;
    rvv_req_vld = 1'b0; rvv_req_len = '0; rvv_beat_vld = 1'b0; use0 = 1'b0; lv_seen = 0;

    // Reset, then NN 0x5A len 3 winning a tie with RVV; RVV wins the next tie.
    add(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0), 2);
    add(mk(1,1,8'h5A,3,0,1,0,0, 1,0,0,0,0,0,0,0,0), 1);
    add(mk(1,0,0,0,1,1,0,0, 0,0,0,1,1,0,0,0,0), 4);
    add(mk(1,0,0,0,0,1,0,0, 0,0,0,1,0,0,0,0,0), 4);
    add(mk(1,0,0,0,0,1,0,0, 0,0,0,1,0,1,8'h5A,0,0), 1);
    add(mk(1,1,8'h11,0,0,1,0,0, 0,1,0,1,0,0,0,0,0), 1);
    add(mk(1,1,8'h11,0,0,0,0,0, 0,0,1,0,0,0,0,0,0), 1);
    add(mk(1,1,8'h11,0,1,0,0,0, 0,0,1,0,0,0,0,0,0), 1);
    add(mk(1,1,8'h11,0,0,0,0,1, 0,0,1,0,1,0,0,0,1), 1);
    add(mk(1,1,8'h11,0,0,0,0,0, 0,0,0,0,0,0,0,0,1), 4);
    add(mk(1,1,8'h11,0,0,0,0,0, 0,0,0,0,0,0,0,1,1), 1);
    add(mk(1,1,8'h11,0,0,0,0,0, 1,0,0,0,0,0,0,0,1), 1);
    add(mk(1,0,0,0,1,0,0,0, 0,0,0,1,1,0,0,0,1), 1);
    add(mk(1,0,0,0,0,0,0,0, 0,0,0,1,0,0,0,0,1), 4);
    add(mk(1,0,0,0,0,0,0,0, 0,0,0,1,0,1,8'h11,0,1), 1);
    add(mk(1,0,0,0,0,0,0,0, 0,0,0,1,0,0,0,0,1), 1);
    // Reset after 2 of 4 beats, new command accepted right after release.
    add(mk(1,1,8'h33,3,0,0,0,0, 1,0,0,1,0,0,0,0,1), 1);
    add(mk(1,0,0,0,1,0,0,0, 0,0,0,1,1,0,0,0,1), 2);
    add(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0), 1);
    add(mk(1,1,8'h44,0,0,0,0,0, 1,0,0,0,0,0,0,0,0), 1);
    add(mk(1,0,0,0,1,0,0,0, 0,0,0,1,1,0,0,0,0), 1);
    add(mk(1,0,0,0,0,0,0,0, 0,0,0,1,0,0,0,0,0), 4);
    add(mk(1,0,0,0,0,0,0,0, 0,0,0,1,0,1,8'h44,0,0), 1);
    add(mk(1,0,0,0,0,0,0,0, 0,0,0,1,0,0,0,0,0), 1);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // LANE_LAT=0 instance: 256 gapped NN beats, done the cycle after the last beat.
    tbl.delete();
    add(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0), 1);
    add(mk(1,1,8'hC3,255,0,0,0,0, 1,0,0,0,0,0,0,0,0), 1);
    k = 0; nb = 0;
    while (nb < 256) begin
      pv = ((k % 5) != 4) ? 1 : 0;
      add(mk(1,0,0,0,pv,0,0,0, 0,0,0,1,pv,0,0,0,0), 1);
      nb += pv;
      k++;
    end
    add(mk(1,0,0,0,0,0,0,0, 0,0,0,1,0,1,8'hC3,0,0), 1);
    add(mk(1,1,8'h07,0,0,0,0,0, 1,0,0,1,0,0,0,0,0), 1);
    use0 = 1'b1;
    lv_seen = 0;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    chk("lat0_lane_vld_count", 32'(lv_seen), 32'd256);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
